// File: rtl/serial_adder_pkg.sv
// Shared constants for the serial adder: default operand width and FSM state
// encodings used by the top-level controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two cascaded half-adder stages; the carry
// out is the OR of the two half-adder carries.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_s;
  logic ha2_c;

  // Two half-adder stages followed by the carry merge.
  always_comb begin
    ha1_s = a_i ^ b_i;
    ha1_c = a_i & b_i;
    ha2_s = ha1_s ^ ci_i;
    ha2_c = ha1_s & ci_i;
    s_o   = ha2_s;
    co_o  = ha1_c | ha2_c;
  end

endmodule : fa_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start, added LSB-first one bit
// per clock through a single full-adder cell, and the result is published on
// sum_o/cout_o together with a one-cycle done_o pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_c)
  );

  // Next-state, datapath and flag computation; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (cnt_q == CNT_LAST) begin
          // Counter stops at its terminal value instead of wrapping.
          sum_d   = {fa_s, psum_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags are registered from the next state so outputs come straight from flops.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       cin_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sum_o;
  logic       cout_o;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] prev_sum  = 8'h00;
  logic       prev_cout = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[10];

  serial_adder #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Assumes start_i and operands are already driven for the next rising edge.
  task automatic finish_op(input logic [7:0] es, input logic ec, input string name);
    int cyc;
    int busy_n;
    bit hold_ok;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    busy_n = 0;
    hold_ok = 1'b1;
    if (busy_o) busy_n++;
    while (!done_o && cyc < 40) begin
      if (sum_o !== prev_sum || cout_o !== prev_cout) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (busy_o) busy_n++;
    end
    check({name, " latency"}, 32'(cyc), 32'd8);
    check({name, " busy cycles"}, 32'(busy_n), 32'd9);
    check({name, " hold"}, 32'(hold_ok), 32'd1);
    check({name, " sum"}, 32'(sum_o), 32'(es));
    check({name, " cout"}, 32'(cout_o), 32'(ec));
    prev_sum  = es;
    prev_cout = ec;
    @(negedge clk);
    check({name, " done width"}, 32'(done_o), 32'd0);
    check({name, " busy after"}, 32'(busy_o), 32'd0);
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input string name);
    @(negedge clk);
    a_i = ta;
    b_i = tb;
    cin_i = tc;
    start_i = 1'b1;
    finish_op(es, ec, name);
  endtask

  initial begin
    int pulses;
    int t_first;
    int t_last;
    int gap_ok;
    bit stable;
    logic [8:0] model;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h3C, 8'h55, 1'b0, 8'h91, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[9] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst_n = 1'b0;
    start_i = 1'b0;
    a_i = 8'h00;
    b_i = 8'h00;
    cin_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset sum", 32'(sum_o), 32'd0);
    check("reset cout", 32'(cout_o), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
             $sformatf("vec%0d", i));
    end

    // Operand changes and start pulses while busy must not disturb the result.
    @(negedge clk);
    a_i = 8'h3C;
    b_i = 8'h55;
    cin_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 9) check("ignore busy idle", 32'(busy_o), 32'd0);
      if (done_o) begin
        pulses++;
        check("ignore sum", 32'(sum_o), 32'h91);
        check("ignore cout", 32'(cout_o), 32'd0);
      end
      start_i = (i <= 8) && (i != 3);
      a_i = 8'($urandom);
      b_i = 8'($urandom);
      cin_i = 1'b1;
      @(negedge clk);
    end
    check("ignore pulses", 32'(pulses), 32'd1);
    start_i = 1'b0;
    prev_sum = 8'h91;
    prev_cout = 1'b0;

    // start held high: back-to-back operations every 10 cycles.
    a_i = 8'h21;
    b_i = 8'h10;
    cin_i = 1'b0;
    start_i = 1'b1;
    pulses = 0;
    t_first = -1;
    t_last = -1;
    gap_ok = 1;
    stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_o) begin
        if (t_last >= 0 && (i - t_last) != 10) gap_ok = 0;
        if (t_first < 0) t_first = i;
        t_last = i;
        pulses++;
      end
      if (t_first >= 0 && (sum_o !== 8'h31 || cout_o !== 1'b0)) stable = 1'b0;
    end
    start_i = 1'b0;
    check("held pulses", 32'(pulses), 32'd3);
    check("held first", 32'(t_first), 32'd8);
    check("held gap", 32'(gap_ok), 32'd1);
    check("held stable", 32'(stable), 32'd1);
    @(negedge clk);
    check("held idle", 32'(busy_o), 32'd0);
    prev_sum = 8'h31;
    prev_cout = 1'b0;

    // Reset in the middle of an operation.
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "pre-reset");
    @(negedge clk);
    a_i = 8'hFF;
    b_i = 8'hFF;
    cin_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy_o), 32'd0);
    check("midreset done", 32'(done_o), 32'd0);
    check("midreset sum", 32'(sum_o), 32'd0);
    check("midreset cout", 32'(cout_o), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_o || busy_o) pulses++;
    end
    check("midreset quiet", 32'(pulses), 32'd0);
    prev_sum = 8'h00;
    prev_cout = 1'b0;
    rst_n = 1'b1;
    a_i = 8'h01;
    b_i = 8'h02;
    cin_i = 1'b0;
    start_i = 1'b1;
    finish_op(8'h03, 1'b0, "post-reset");

    // Randomized operations against a+b+cin.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      run_op(ra, rb, rc, model[7:0], model[8], $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_adder
